// File: rtl/berexp_feeder.sv
// Issue/return controller for the Bernoulli-exponential rejection stage.
// Pairs candidates with PRNG bytes, tracks tags across BerExp and buffers accepted samples.
module berexp_feeder #(
  parameter int DEPTH   = 8,
  parameter int Z_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cand_val_i,
  output logic                       cand_rdy_o,
  input  logic [Z_WIDTH-1:0]         cand_z_i,
  input  logic [63:0]                cand_x_i,
  input  logic [63:0]                cand_ccs_i,
  input  logic                       rnd_val_i,
  output logic                       rnd_rdy_o,
  input  logic [7:0]                 rnd_i,
  output logic                       be_din_val_o,
  output logic [63:0]                be_x_o,
  output logic [63:0]                be_ccs_o,
  output logic [7:0]                 be_rand_8_o,
  input  logic                       be_dout_val_i,
  input  logic                       be_w_i,
  output logic                       acc_val_o,
  input  logic                       acc_rdy_i,
  output logic [Z_WIDTH-1:0]         acc_z_o,
  output logic                       rej_pulse_o,
  output logic [31:0]                rej_cnt_o,
  output logic [$clog2(DEPTH):0]     inflight_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // The tag FIFO occupancy always equals the in-flight count, so one counter serves both.
  logic [Z_WIDTH-1:0] tag_mem [DEPTH];
  logic [AW-1:0]      tag_wr_q, tag_rd_q;
  logic [CW-1:0]      inflight_q;

  logic [Z_WIDTH-1:0] res_mem [DEPTH];
  logic [AW-1:0]      res_wr_q, res_rd_q;
  logic [CW-1:0]      res_cnt_q;

  logic [CW:0]        occ;
  logic               can_issue;
  logic               fire;
  logic               tag_empty;
  logic               ret_ok;
  logic               res_push;
  logic               res_pop;
  logic [Z_WIDTH-1:0] tag_head;

  assign occ       = {1'b0, inflight_q} + {1'b0, res_cnt_q};
  assign can_issue = (occ < (CW+1)'(DEPTH));

  // Ready terms are combinational; masking with rst keeps them low throughout reset.
  assign cand_rdy_o = rnd_val_i  & can_issue & ~rst;
  assign rnd_rdy_o  = cand_val_i & can_issue & ~rst;
  assign fire       = cand_val_i & rnd_val_i & can_issue & ~rst;

  assign tag_empty = (inflight_q == '0);
  assign ret_ok    = be_dout_val_i & ~tag_empty;
  assign tag_head  = tag_mem[tag_rd_q];

  assign acc_val_o = (res_cnt_q != '0);
  assign acc_z_o   = acc_val_o ? res_mem[res_rd_q] : '0;
  assign res_push  = ret_ok & be_w_i;
  assign res_pop   = acc_val_o & acc_rdy_i;

  assign inflight_o = inflight_q;

  // NOTE: FIFO storage has no reset; the pointers and counts define validity, and
  // leaving the arrays unreset lets them map onto plain register files or RAM.
  always_ff @(posedge clk) begin
    if (fire)     tag_mem[tag_wr_q] <= cand_z_i;
    if (res_push) res_mem[res_wr_q] <= tag_head;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      inflight_q   <= '0;
      res_wr_q     <= '0;
      res_rd_q     <= '0;
      res_cnt_q    <= '0;
      be_din_val_o <= 1'b0;
      be_x_o       <= '0;
      be_ccs_o     <= '0;
      be_rand_8_o  <= '0;
      rej_pulse_o  <= 1'b0;
      rej_cnt_o    <= '0;
      err_o        <= 1'b0;
    end else begin
      be_din_val_o <= fire;
      if (fire) begin
        be_x_o      <= cand_x_i;
        be_ccs_o    <= cand_ccs_i;
        be_rand_8_o <= rnd_i;
        tag_wr_q    <= tag_wr_q + AW'(1);
      end

      if (ret_ok) tag_rd_q <= tag_rd_q + AW'(1);

      unique case ({fire, ret_ok})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase

      if (res_push) res_wr_q <= res_wr_q + AW'(1);
      if (res_pop)  res_rd_q <= res_rd_q + AW'(1);

      unique case ({res_push, res_pop})
        2'b10:   res_cnt_q <= res_cnt_q + CW'(1);
        2'b01:   res_cnt_q <= res_cnt_q - CW'(1);
        default: res_cnt_q <= res_cnt_q;
      endcase

      rej_pulse_o <= ret_ok & ~be_w_i;
      if (ret_ok && !be_w_i && rej_cnt_o != 32'hFFFF_FFFF)
        rej_cnt_o <= rej_cnt_o + 32'd1;

      // A return with nothing outstanding means BerExp and this block disagree.
      if (be_dout_val_i && tag_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_berexp_feeder.sv
// Scoreboard bench for berexp_feeder: directed scenarios plus a randomised run
// against a fixed-latency BerExp model.
module tb_berexp_feeder;

  localparam int DEPTH = 4;
  localparam int ZW    = 16;
  localparam int LAT   = 4;

  logic            clk;
  logic            rst;
  logic            cand_val_i;
  logic            cand_rdy_o;
  logic [ZW-1:0]   cand_z_i;
  logic [63:0]     cand_x_i;
  logic [63:0]     cand_ccs_i;
  logic            rnd_val_i;
  logic            rnd_rdy_o;
  logic [7:0]      rnd_i;
  logic            be_din_val_o;
  logic [63:0]     be_x_o;
  logic [63:0]     be_ccs_o;
  logic [7:0]      be_rand_8_o;
  logic            be_dout_val_i;
  logic            be_w_i;
  logic            acc_val_o;
  logic            acc_rdy_i;
  logic [ZW-1:0]   acc_z_o;
  logic            rej_pulse_o;
  logic [31:0]     rej_cnt_o;
  logic [2:0]      inflight_o;
  logic            err_o;

  berexp_feeder #(.DEPTH(DEPTH), .Z_WIDTH(ZW)) dut (
    .clk(clk), .rst(rst),
    .cand_val_i(cand_val_i), .cand_rdy_o(cand_rdy_o), .cand_z_i(cand_z_i),
    .cand_x_i(cand_x_i), .cand_ccs_i(cand_ccs_i),
    .rnd_val_i(rnd_val_i), .rnd_rdy_o(rnd_rdy_o), .rnd_i(rnd_i),
    .be_din_val_o(be_din_val_o), .be_x_o(be_x_o), .be_ccs_o(be_ccs_o),
    .be_rand_8_o(be_rand_8_o), .be_dout_val_i(be_dout_val_i), .be_w_i(be_w_i),
    .acc_val_o(acc_val_o), .acc_rdy_i(acc_rdy_i), .acc_z_o(acc_z_o),
    .rej_pulse_o(rej_pulse_o), .rej_cnt_o(rej_cnt_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_rej = 0;
  logic        fired;
  logic        model_en = 1'b0;
  logic [ZW-1:0] exp_q[$];
  logic [ZW-1:0] lz[$];
  logic        pipe_v [LAT];
  logic        pipe_w [LAT];

  // One clock: record the handshake and any result pop before the edge, then
  // advance the BerExp model after it.
  task automatic tick();
    logic [ZW-1:0] ez;
    logic          w;
    #1;
    fired = cand_val_i & cand_rdy_o;
    if (fired && model_en) lz.push_back(cand_z_i);
    if (acc_val_o && acc_rdy_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL acc_pop_unexpected: got z=%h, none expected", acc_z_o);
      end else begin
        ez = exp_q.pop_front();
        if (acc_z_o !== ez) begin
          n_bad++; $display("FAIL acc_order: got z=%h, expected %h", acc_z_o, ez);
        end
      end
    end
    @(posedge clk); #1;
    if (model_en) begin
      for (int k = LAT-1; k > 0; k--) begin
        pipe_v[k] = pipe_v[k-1];
        pipe_w[k] = pipe_w[k-1];
      end
      w = ($urandom_range(0, 99) < 70);
      pipe_v[0] = be_din_val_o;
      pipe_w[0] = w;
      if (be_din_val_o) begin
        n_cmp++;
        if (lz.size() == 0) begin
          n_bad++; $display("FAIL model_launch: got a launch, expected none pending");
        end else begin
          ez = lz.pop_front();
          if (w) exp_q.push_back(ez);
          else   exp_rej++;
        end
      end
      be_dout_val_i = pipe_v[LAT-1];
      be_w_i        = pipe_w[LAT-1];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cand_val_i = 1'b1; rnd_val_i = 1'b1; acc_rdy_i = 1'b1;
    be_dout_val_i = 1'b0; be_w_i = 1'b0;
    cand_z_i = 16'h1111; cand_x_i = 64'h1; cand_ccs_i = 64'h2; rnd_i = 8'h33;
    repeat (3) tick();
    n_cmp++; if ({cand_rdy_o, rnd_rdy_o} !== 2'b00) begin n_bad++; $display("FAIL reset_rdy: got %b, expected 00", {cand_rdy_o, rnd_rdy_o}); end
    n_cmp++; if ({be_din_val_o, be_x_o, be_ccs_o, be_rand_8_o} !== '0) begin n_bad++; $display("FAIL reset_be: got val=%b rand=%h, expected all 0", be_din_val_o, be_rand_8_o); end
    n_cmp++; if ({acc_val_o, acc_z_o, rej_pulse_o, rej_cnt_o, inflight_o, err_o} !== '0) begin n_bad++; $display("FAIL reset_status: got acc=%b z=%h rej=%0d infl=%0d err=%b, expected all 0", acc_val_o, acc_z_o, rej_cnt_o, inflight_o, err_o); end
    rst = 1'b0; cand_val_i = 1'b0; rnd_val_i = 1'b0; acc_rdy_i = 1'b0;
    tick();
  endtask

  task automatic test_single(input logic w);
    cand_z_i = 16'h1234; cand_x_i = 64'h3FF0_0000_0000_0001; cand_ccs_i = 64'h3FE8_0000_0000_0002;
    rnd_i = 8'hA5; cand_val_i = 1'b1; rnd_val_i = 1'b1;
    tick();
    cand_val_i = 1'b0; rnd_val_i = 1'b0;
    n_cmp++; if ({fired, be_din_val_o} !== 2'b11) begin n_bad++; $display("FAIL single_launch: got fire=%b din_val=%b, expected 11", fired, be_din_val_o); end
    n_cmp++; if (be_rand_8_o !== 8'hA5) begin n_bad++; $display("FAIL single_rand: got %h, expected a5", be_rand_8_o); end
    n_cmp++; if ({be_x_o, be_ccs_o} !== {64'h3FF0_0000_0000_0001, 64'h3FE8_0000_0000_0002}) begin n_bad++; $display("FAIL single_data: got x=%h ccs=%h", be_x_o, be_ccs_o); end
    n_cmp++; if (inflight_o !== 3'd1) begin n_bad++; $display("FAIL single_inflight: got %0d, expected 1", inflight_o); end
    repeat (9) tick();
    n_cmp++; if ({be_din_val_o, be_rand_8_o, acc_val_o} !== {1'b0, 8'hA5, 1'b0}) begin n_bad++; $display("FAIL single_hold: got din_val=%b rand=%h acc=%b, expected 0 a5 0", be_din_val_o, be_rand_8_o, acc_val_o); end
    be_dout_val_i = 1'b1; be_w_i = w;
    tick();
    be_dout_val_i = 1'b0; be_w_i = 1'b0;
    if (w) begin
      n_cmp++; if ({acc_val_o, acc_z_o, rej_pulse_o} !== {1'b1, 16'h1234, 1'b0}) begin n_bad++; $display("FAIL accept_out: got acc=%b z=%h rej=%b, expected 1 1234 0", acc_val_o, acc_z_o, rej_pulse_o); end
      n_cmp++; if (rej_cnt_o !== 32'(exp_rej)) begin n_bad++; $display("FAIL accept_rejcnt: got %0d, expected %0d", rej_cnt_o, exp_rej); end
      n_cmp++; if (inflight_o !== 3'd0) begin n_bad++; $display("FAIL accept_inflight: got %0d, expected 0", inflight_o); end
      exp_q.push_back(16'h1234);
      acc_rdy_i = 1'b1;
      tick();
      acc_rdy_i = 1'b0;
      n_cmp++; if (acc_val_o !== 1'b0) begin n_bad++; $display("FAIL accept_drained: got acc_val=%b, expected 0", acc_val_o); end
    end else begin
      exp_rej++;
      n_cmp++; if ({rej_pulse_o, acc_val_o} !== 2'b10) begin n_bad++; $display("FAIL reject_out: got pulse=%b acc=%b, expected 1 0", rej_pulse_o, acc_val_o); end
      n_cmp++; if (rej_cnt_o !== 32'(exp_rej)) begin n_bad++; $display("FAIL reject_cnt: got %0d, expected %0d", rej_cnt_o, exp_rej); end
      n_cmp++; if (inflight_o !== 3'd0) begin n_bad++; $display("FAIL reject_inflight: got %0d, expected 0", inflight_o); end
      tick();
      n_cmp++; if (rej_pulse_o !== 1'b0) begin n_bad++; $display("FAIL reject_pulse_width: got %b, expected 0", rej_pulse_o); end
    end
  endtask

  task automatic test_three_way();
    cand_z_i = 16'h0777; rnd_i = 8'h3C; cand_val_i = 1'b1; rnd_val_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if ({fired, cand_rdy_o, rnd_rdy_o, be_din_val_o, inflight_o} !== {4'b0010, 3'd0}) begin n_bad++; $display("FAIL three_way_stall: got fire=%b crdy=%b rrdy=%b din=%b infl=%0d", fired, cand_rdy_o, rnd_rdy_o, be_din_val_o, inflight_o); end
    end
    rnd_val_i = 1'b1;
    tick();
    cand_val_i = 1'b0; rnd_val_i = 1'b0;
    n_cmp++; if ({fired, be_din_val_o, be_rand_8_o, inflight_o} !== {2'b11, 8'h3C, 3'd1}) begin n_bad++; $display("FAIL three_way_fire: got fire=%b din=%b rand=%h infl=%0d", fired, be_din_val_o, be_rand_8_o, inflight_o); end
    be_dout_val_i = 1'b1; be_w_i = 1'b0;
    tick();
    be_dout_val_i = 1'b0;
    exp_rej++;
    n_cmp++; if ({rej_cnt_o, inflight_o} !== {32'(exp_rej), 3'd0}) begin n_bad++; $display("FAIL three_way_return: got rej=%0d infl=%0d, expected %0d 0", rej_cnt_o, inflight_o, exp_rej); end
  endtask

  task automatic test_credit_stall();
    int nf = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(16'hC000 + 16'(i));
    cand_val_i = 1'b1; rnd_val_i = 1'b1; acc_rdy_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cand_z_i = 16'hC000 + 16'(nf); rnd_i = 8'(nf);
      tick();
      if (fired) nf++;
    end
    n_cmp++; if ({nf == 4, cand_rdy_o, inflight_o} !== {2'b10, 3'd4}) begin n_bad++; $display("FAIL credit_fill: got fires=%0d crdy=%b infl=%0d, expected 4 0 4", nf, cand_rdy_o, inflight_o); end
    be_dout_val_i = 1'b1; be_w_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fired) nf++;
    end
    be_dout_val_i = 1'b0;
    n_cmp++; if ({nf == 4, cand_rdy_o, inflight_o, acc_val_o, acc_z_o} !== {2'b10, 3'd0, 1'b1, 16'hC000}) begin n_bad++; $display("FAIL credit_full: got fires=%0d crdy=%b infl=%0d acc=%b z=%h", nf, cand_rdy_o, inflight_o, acc_val_o, acc_z_o); end
    acc_rdy_i = 1'b1;
    tick();
    acc_rdy_i = 1'b0;
    if (fired) nf++;
    n_cmp++; if ({nf == 4, cand_rdy_o} !== 2'b11) begin n_bad++; $display("FAIL credit_release: got fires=%0d crdy=%b, expected 4 1", nf, cand_rdy_o); end
    tick();
    if (fired) nf++;
    n_cmp++; if ({fired, nf == 5, cand_rdy_o} !== 3'b110) begin n_bad++; $display("FAIL credit_refire: got fire=%b fires=%0d crdy=%b, expected 1 5 0", fired, nf, cand_rdy_o); end
    for (int c = 0; c < 30 && !(nf == 6 && exp_q.size() == 0 && inflight_o == 3'd0); c++) begin
      cand_val_i = (nf < 6); cand_z_i = 16'hC000 + 16'(nf);
      be_dout_val_i = (inflight_o != 3'd0); be_w_i = 1'b1; acc_rdy_i = 1'b1;
      tick();
      if (fired) nf++;
    end
    cand_val_i = 1'b0; rnd_val_i = 1'b0; be_dout_val_i = 1'b0; acc_rdy_i = 1'b0;
    n_cmp++; if ({nf == 6, exp_q.size() == 0, acc_val_o, err_o} !== 4'b1100) begin n_bad++; $display("FAIL credit_drain: got fires=%0d left=%0d acc=%b err=%b, expected 6 0 0 0", nf, exp_q.size(), acc_val_o, err_o); end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(16'h0A01); exp_q.push_back(16'h0A02); exp_q.push_back(16'h0A03);
    cand_val_i = 1'b1; rnd_val_i = 1'b1;
    cand_z_i = 16'h0A01; tick();
    cand_z_i = 16'h0A02; tick();
    cand_val_i = 1'b0;
    be_dout_val_i = 1'b1; be_w_i = 1'b1;
    tick();
    n_cmp++; if ({inflight_o, acc_val_o, acc_z_o} !== {3'd1, 1'b1, 16'h0A01}) begin n_bad++; $display("FAIL simul_setup: got infl=%0d acc=%b z=%h, expected 1 1 0a01", inflight_o, acc_val_o, acc_z_o); end
    cand_val_i = 1'b1; cand_z_i = 16'h0A03; acc_rdy_i = 1'b1;
    tick();
    cand_val_i = 1'b0;
    n_cmp++; if ({fired, be_din_val_o, inflight_o, acc_val_o, acc_z_o} !== {2'b11, 3'd1, 1'b1, 16'h0A02}) begin n_bad++; $display("FAIL simul_step: got fire=%b din=%b infl=%0d acc=%b z=%h, expected 1 1 1 1 0a02", fired, be_din_val_o, inflight_o, acc_val_o, acc_z_o); end
    tick();
    be_dout_val_i = 1'b0;
    tick();
    acc_rdy_i = 1'b0;
    n_cmp++; if ({inflight_o, acc_val_o, exp_q.size() == 0} !== {3'd0, 2'b01}) begin n_bad++; $display("FAIL simul_drain: got infl=%0d acc=%b left=%0d", inflight_o, acc_val_o, exp_q.size()); end
  endtask

  task automatic test_random();
    int sent = 0;
    logic done = 1'b0;
    for (int k = 0; k < LAT; k++) begin pipe_v[k] = 1'b0; pipe_w[k] = 1'b0; end
    lz.delete();
    model_en = 1'b1;
    for (int c = 0; c < 5000 && !done; c++) begin
      cand_val_i = (sent < 100) && ($urandom_range(0, 9) < 8);
      rnd_val_i  = ($urandom_range(0, 9) < 8);
      cand_z_i   = 16'($urandom);
      cand_x_i   = {$urandom, $urandom};
      cand_ccs_i = {$urandom, $urandom};
      rnd_i      = 8'($urandom);
      acc_rdy_i  = ($urandom_range(0, 9) < 7);
      tick();
      if (fired) sent++;
      done = (sent == 100) && (inflight_o == 3'd0) && !acc_val_o;
    end
    model_en = 1'b0;
    cand_val_i = 1'b0; rnd_val_i = 1'b0; acc_rdy_i = 1'b0; be_dout_val_i = 1'b0; be_w_i = 1'b0;
    n_cmp++; if (!done) begin n_bad++; $display("FAIL random_timeout: got sent=%0d infl=%0d, expected 100 jobs completed", sent, inflight_o); end
    n_cmp++; if ({exp_q.size() == 0, lz.size() == 0, err_o} !== 3'b110) begin n_bad++; $display("FAIL random_residue: got acc_left=%0d launch_left=%0d err=%b", exp_q.size(), lz.size(), err_o); end
    n_cmp++; if (rej_cnt_o !== 32'(exp_rej)) begin n_bad++; $display("FAIL random_rejcnt: got %0d, expected %0d", rej_cnt_o, exp_rej); end
  endtask

  task automatic test_err_reset();
    be_dout_val_i = 1'b1; be_w_i = 1'b1;
    tick();
    be_dout_val_i = 1'b0;
    n_cmp++; if ({err_o, inflight_o, acc_val_o} !== {1'b1, 3'd0, 1'b0}) begin n_bad++; $display("FAIL err_set: got err=%b infl=%0d acc=%b, expected 1 0 0", err_o, inflight_o, acc_val_o); end
    repeat (3) tick();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b, expected 1", err_o); end
    cand_val_i = 1'b1; rnd_val_i = 1'b1;
    for (int i = 0; i < 3; i++) begin cand_z_i = 16'hE000 + 16'(i); tick(); end
    n_cmp++; if (inflight_o !== 3'd3) begin n_bad++; $display("FAIL err_inflight3: got %0d, expected 3", inflight_o); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({cand_rdy_o, rnd_rdy_o, be_din_val_o, be_x_o, be_ccs_o, be_rand_8_o, acc_val_o, acc_z_o, rej_pulse_o, rej_cnt_o, inflight_o, err_o} !== '0) begin n_bad++; $display("FAIL midrun_reset: got crdy=%b din=%b rej=%0d infl=%0d err=%b, expected all 0", cand_rdy_o, be_din_val_o, rej_cnt_o, inflight_o, err_o); end
    repeat (2) tick();
    rst = 1'b0; exp_rej = 0;
    cand_z_i = 16'hBEEF; rnd_i = 8'h5A;
    tick();
    cand_val_i = 1'b0; rnd_val_i = 1'b0;
    n_cmp++; if ({fired, be_din_val_o, be_rand_8_o, inflight_o} !== {2'b11, 8'h5A, 3'd1}) begin n_bad++; $display("FAIL post_reset_fire: got fire=%b din=%b rand=%h infl=%0d", fired, be_din_val_o, be_rand_8_o, inflight_o); end
    be_dout_val_i = 1'b1; be_w_i = 1'b1;
    tick();
    be_dout_val_i = 1'b0;
    n_cmp++; if ({acc_val_o, acc_z_o, err_o, rej_cnt_o} !== {1'b1, 16'hBEEF, 1'b0, 32'd0}) begin n_bad++; $display("FAIL post_reset_accept: got acc=%b z=%h err=%b rej=%0d", acc_val_o, acc_z_o, err_o, rej_cnt_o); end
    exp_q.push_back(16'hBEEF);
    acc_rdy_i = 1'b1;
    tick();
    acc_rdy_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(1'b1);
    test_single(1'b0);
    test_three_way();
    test_credit_stall();
    test_simultaneous();
    test_random();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/berexp_feeder.md
# berexp_feeder

Issue-side controller for the Bernoulli-exponential rejection stage of the sampler. It pairs each candidate (z, x, ccs) with a random byte from the PRNG stream and launches it into the BerExp unit. It also tracks the candidate value across the unit's fixed pipeline, then forwards accepted candidates downstream or counts the rejection. The BerExp unit has no backpressure, so this block uses credit-based flow control to ensure every in-flight result has a guaranteed slot in the result FIFO.

## Interface
- DEPTH, 8: tag/result FIFO depth and maximum in-flight + buffered jobs; power of 2, ≥2
- Z_WIDTH, 16: width of candidate sample z
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cand_val_i  in  1  candidate valid
- cand_rdy_o  out  1  candidate accepted this cycle when high with cand_val_i
- cand_z_i  in  Z_WIDTH  candidate sample
- cand_x_i  in  64  double x for BerExp
- cand_ccs_i  in  64  double ccs for BerExp
- rnd_val_i  in  1  random byte valid
- rnd_rdy_o  out  1  random byte consumed
- rnd_i  in  8  random byte
- be_din_val_o  out  1  one-cycle launch strobe to BerExp
- be_x_o  out  64  x to BerExp
- be_ccs_o  out  64  ccs to BerExp
- be_rand_8_o  out  8  random byte to BerExp
- be_dout_val_i  in  1  BerExp result strobe
- be_w_i  in  1  BerExp decision, 1 = accept
- acc_val_o  out  1  accepted sample available
- acc_rdy_i  in  1  downstream takes accepted sample
- acc_z_o  out  Z_WIDTH  accepted sample (FIFO head)
- rej_pulse_o  out  1  one-cycle pulse per rejection
- rej_cnt_o  out  32  rejection counter, saturating
- inflight_o  out  $clog2(DEPTH)+1  jobs launched but not yet returned
- err_o  out  1  sticky protocol error

## Operation
- Credit: occ = inflight + result FIFO count, both from registers. can_issue = (occ < DEPTH).
- Issue handshake is three-way: fire = cand_val_i & rnd_val_i & can_issue.
  - cand_rdy_o = rnd_val_i & can_issue.
  - rnd_rdy_o = cand_val_i & can_issue.
  - Neither is consumed alone.
- On fire:
  - Register x, ccs, and rnd into the be_* outputs.
  - Set be_din_val_o = 1 for exactly the next cycle.
  - Push cand_z_i into the tag FIFO.
  - Increment inflight.
- be_* data outputs hold their last launched value while be_din_val_o = 0.
- On be_dout_val_i with tag FIFO non-empty:
  - Pop the tag FIFO and decrement inflight.
  - If be_w_i = 1, push the tag into the result FIFO.
  - Else assert rej_pulse_o and increment rej_cnt_o, holding at 0xFFFFFFFF once reached.
- On be_dout_val_i with tag FIFO empty:
  - No pop, no push, no count.
  - err_o sets and stays set until rst.
- Fire and return in the same cycle: inflight unchanged, tag FIFO pushes and pops. Results return in launch order (BerExp is fixed-latency), so the tag FIFO head always matches the returning result.
- Result FIFO is first-word-fall-through:
  - acc_val_o = not empty; acc_z_o = head.
  - Pop on acc_val_o & acc_rdy_i.
  - Simultaneous push and pop is legal at any occupancy.
- The credit rule guarantees the result FIFO never overflows. Credit freed by a pop or a rejection becomes usable the following cycle; there is no same-cycle bypass.
- Reset, at any time:
  - Both FIFOs empty; inflight, rej_cnt_o, and err_o cleared.
  - All outputs 0.
  - Jobs in flight inside BerExp are abandoned. Their returns after reset hit an empty tag FIFO and set err_o, so BerExp must be reset with this block.

## Timing
- Fire at cycle T → be_din_val_o = 1 at T+1 and the be_* data are valid at T+1.
- Back-to-back fires are allowed every cycle while credit remains.
- be_dout_val_i at R with w = 1 → acc_val_o = 1 at R+1 with acc_z_o equal to the tag.
- be_dout_val_i at R with w = 0 → rej_pulse_o = 1 at R+1 and rej_cnt_o incremented at R+1.
- inflight_o updates at the cycle after the fire or return that changes it.
- Reset values: every output 0, including cand_rdy_o and rnd_rdy_o, which stay 0 while rst is high.

## Test plan
- Single accept. DEPTH=8. Send cand z=0x1234 with rnd=0xA5 at T. Return be_dout_val_i at T+10 with w=1. Expect:
  - be_din_val_o and be_rand_8_o=0xA5 at T+1.
  - acc_val_o with acc_z_o=0x1234 at T+11.
  - rej_cnt_o=0.
- Reject. Same stimulus with w=0. Expect rej_pulse_o at T+11, rej_cnt_o=1, acc_val_o stays 0, inflight_o back to 0.
- Credit stall. DEPTH=4, acc_rdy_i=0, 6 candidates offered, all accepted by BerExp. Expect:
  - Exactly 4 fires, then cand_rdy_o=0.
  - After one acc_rdy_i pop, one further fire the next cycle.
  - Output order z0..z3.
- Three-way handshake. cand_val_i=1 with rnd_val_i=0 for 5 cycles. Expect cand_rdy_o=0, no launch, no tag push. Raise rnd_val_i and expect a fire that cycle.
- Simultaneous events. Steady state: fire, return (w=1), and acc pop all in one cycle. Expect inflight_o and result count both unchanged, and no data loss over a 100-job random run checked against a reference model.
- Errors and reset. Drive be_dout_val_i with nothing in flight → err_o=1 next cycle and sticky. Assert rst mid-run with 3 jobs in flight → all outputs 0 and inflight_o=0. Accept a new candidate after rst is released.
